reg_transfer_ctrl: RTL and testbench
====================================

REG_TRANSFER_CTRL -- requirements
Module: reg_transfer_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3: register address width (8 registers).
REQ-002 SHALL have parameter DWIDTH, default `DATA_WIDTH: bus data width.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  transfer request, sampled only in IDLE.
REQ-006 SHALL have port op  input  2  00 MOV src->dst, 01 LDI imm->dst, 10 RD src->rdata, 11 SWAP/illegal.
REQ-007 SHALL have port src  input  ADDR_WIDTH  source register address.
REQ-008 SHALL have port dst  input  ADDR_WIDTH  destination register address.
REQ-009 SHALL have port imm  input  DWIDTH  immediate for LDI.
REQ-010 SHALL have port busy  output  1  high from acceptance until done.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  one-cycle pulse with done on an illegal op.
REQ-013 SHALL have port rdata  output  DWIDTH  last RD result, held until the next RD.
REQ-014 SHALL have port address  output  ADDR_WIDTH  register bank address.
REQ-015 SHALL have port CS  output  1  register bank chip select.
REQ-016 SHALL have port RD_WR  output  1  1=read, 0=write.
REQ-017 SHALL have port data  inout  DWIDTH  shared register bank bus.

Function
REQ-018 SHALL implement FSM states IDLE, RD_A, RD_B, WR_A, WR_B, DONE, all registered.
REQ-019 SHALL accept a request at a rising edge in IDLE with req=1, latching op, src, dst and imm; busy=1 from the next cycle.
REQ-020 SHALL ignore req while busy; latched operands are unaffected by input changes.
REQ-021 Bus cycles: read = CS=1, RD_WR=1, address=src; write = CS=1, RD_WR=0, address=dst, data driven.
REQ-022 SHALL capture read data from data into the internal temp register at the rising edge ending each read cycle.
REQ-023 MOV SHALL run IDLE->RD_A->WR_A->DONE: 2 bus cycles, with done in the 3rd cycle after acceptance.
REQ-024 LDI SHALL run IDLE->WR_A(imm)->DONE: done in the 2nd cycle after acceptance.
REQ-025 RD SHALL run IDLE->RD_A->DONE, load rdata at the end of RD_A, and issue no write.
REQ-026 SHALL drive data only in write states and hold it at high-Z in every other state.
REQ-027 SHALL hold CS=0 in IDLE and DONE, with address and RD_WR don't-care; RD_WR=1 when CS=0.
REQ-028 DONE SHALL last exactly one cycle and return to IDLE; a req arriving in DONE is ignored.
REQ-029 src==dst MOV SHALL perform both bus cycles normally.

Reset
REQ-030 Asserting reset (low) at any time SHALL force IDLE, busy=0, done=0, err=0, CS=0, RD_WR=1, address=0, rdata=0, temp=0, data=high-Z.
REQ-031 An in-flight transfer aborted by reset SHALL NOT complete after release; the first request is accepted at the first rising edge with reset=1.

Configuration
REQ-032 With XFER_SWAP_EN defined, op 11 SHALL perform SWAP: RD_A(src)->RD_B(dst)->WR_A(dst<-src value)->WR_B(src<-dst value)->DONE, with done in the 5th cycle after acceptance and err=0.
REQ-033 Without XFER_SWAP_EN, op 11 SHALL go IDLE->DONE with done=1 and err=1, no bus activity; RD_B and WR_B are then unreachable.

Structure
REQ-034 Op encodings and FSM state encodings SHALL be `defines in includes.v alongside `DATA_WIDTH.
REQ-035 The tristate data driver SHALL be a sub-module named bus_driver (en, din, bus); all other logic sits in reg_transfer_ctrl.

Verification
REQ-036 LDI dst=3 imm=8'hA5, then RD src=3 -> rdata=8'hA5; the done pulses are 2 and 2 cycles after acceptance.
REQ-037 LDI r1=8'h3C; MOV src=1 dst=6; RD 6 -> rdata=8'h3C, with done 3 cycles after MOV acceptance and r1 unchanged.
REQ-038 With XFER_SWAP_EN: r2=8'h11, r5=8'hEE; SWAP src=2 dst=5 -> RD 2 returns 8'hEE and RD 5 returns 8'h11; without the macro, op 11 -> done=err=1 and CS never asserted.
REQ-039 A second req during a busy MOV -> ignored, with exactly one done pulse.
REQ-040 Reset pulled low during WR_A of a MOV -> CS=0 and data=Z immediately, with no done; a subsequent RD returns the register's prior value.
REQ-041 Bus monitor for every case -> data is never driven while RD_WR=1, and CS is never high in IDLE or DONE.

Source files
------------

// File: rtl/reg_transfer_ctrl_pkg.sv
// reg_transfer_ctrl_pkg -- op and FSM encodings for the register transfer
// controller, plus the bus data width.
// Optional feature macro: XFER_SWAP_EN (op 11 performs SWAP instead of error).
// The `define block carries the shared includes (DATA_WIDTH, op and state codes)
// so every file of the slice sees the same encodings.
`ifndef REG_TRANSFER_CTRL_DEFINES
`define REG_TRANSFER_CTRL_DEFINES
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`define OP_MOV   2'b00
`define OP_LDI   2'b01
`define OP_RD    2'b10
`define OP_SWAP  2'b11
`define ST_IDLE  3'd0
`define ST_RD_A  3'd1
`define ST_RD_B  3'd2
`define ST_WR_A  3'd3
`define ST_WR_B  3'd4
`define ST_DONE  3'd5
`endif

package reg_transfer_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MOV  = `OP_MOV,
    OP_LDI  = `OP_LDI,
    OP_RD   = `OP_RD,
    OP_SWAP = `OP_SWAP
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = `ST_IDLE,
    ST_RD_A = `ST_RD_A,
    ST_RD_B = `ST_RD_B,
    ST_WR_A = `ST_WR_A,
    ST_WR_B = `ST_WR_B,
    ST_DONE = `ST_DONE
  } state_e;

`ifdef XFER_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  // An op is legal unless it is the SWAP code in a build without SWAP.
  function automatic logic op_legal(op_e op);
    return (op != OP_SWAP) || SWAP_EN;
  endfunction

endpackage

// File: rtl/reg_transfer_ctrl_if.sv
// reg_transfer_ctrl_if -- request/status handshake and register bank control
// lines. The shared data bus is a resolved tristate net and stays a plain
// port on the controller.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface reg_transfer_ctrl_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DWIDTH     = `DATA_WIDTH
);
  import reg_transfer_ctrl_pkg::*;

  logic                  req;
  logic [1:0]            op;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] dst;
  logic [DWIDTH-1:0]     imm;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DWIDTH-1:0]     rdata;
  logic [ADDR_WIDTH-1:0] address;
  logic                  CS;
  logic                  RD_WR;

  // Requester side.
  modport master (
    output req, op, src, dst, imm,
    input  busy, done, err, rdata, address, CS, RD_WR
  );

  // Controller side.
  modport slave (
    input  req, op, src, dst, imm,
    output busy, done, err, rdata, address, CS, RD_WR
  );

endinterface

// File: rtl/reg_transfer_ctrl_bus_driver.sv
// bus_driver -- tristate driver for the shared register bank data bus.
module bus_driver #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = en ? din : {WIDTH{1'bz}};

endmodule

// File: rtl/reg_transfer_ctrl.sv
// reg_transfer_ctrl -- moves data between registers of an external bank over a
// shared tristate bus: MOV, LDI, RD and (with XFER_SWAP_EN) SWAP. Without
// XFER_SWAP_EN, op 11 completes immediately with err and no bus activity.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module reg_transfer_ctrl
  import reg_transfer_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DWIDTH     = `DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  reg_transfer_ctrl_if.slave xif,
  inout  wire  [DWIDTH-1:0] data
);

  state_e                state_reg;
  op_e                   op_reg;
  op_e                   req_op;
  logic [ADDR_WIDTH-1:0] src_reg;
  logic [ADDR_WIDTH-1:0] dst_reg;
  logic [DWIDTH-1:0]     temp_reg;     // first value read (src)
  logic [DWIDTH-1:0]     temp_b_reg;   // second value read (dst, SWAP only)
  logic [DWIDTH-1:0]     wdata_reg;    // value driven during a write cycle
  logic                  data_oe_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic [DWIDTH-1:0]     rdata_reg;
  logic [ADDR_WIDTH-1:0] address_reg;
  logic                  cs_reg;
  logic                  rd_wr_reg;

  assign req_op = op_e'(xif.op);

  // Transfer FSM; all bus controls and status flags are registered with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      op_reg      <= OP_MOV;
      src_reg     <= '0;
      dst_reg     <= '0;
      temp_reg    <= '0;
      temp_b_reg  <= '0;
      wdata_reg   <= '0;
      data_oe_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
      address_reg <= '0;
      cs_reg      <= 1'b0;
      rd_wr_reg   <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (xif.req) begin
            op_reg   <= req_op;
            src_reg  <= xif.src;
            dst_reg  <= xif.dst;
            busy_reg <= 1'b1;
            if (req_op == OP_LDI) begin
              // Immediate goes straight to a write cycle.
              state_reg   <= ST_WR_A;
              cs_reg      <= 1'b1;
              rd_wr_reg   <= 1'b0;
              address_reg <= xif.dst;
              wdata_reg   <= xif.imm;
              data_oe_reg <= 1'b1;
            end else if (op_legal(req_op)) begin
              // MOV, RD and SWAP all start by reading src.
              state_reg   <= ST_RD_A;
              cs_reg      <= 1'b1;
              rd_wr_reg   <= 1'b1;
              address_reg <= xif.src;
            end else begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end
          end
        end
        ST_RD_A: begin
          temp_reg <= data;
          if (op_reg == OP_RD) begin
            rdata_reg <= data;
            state_reg <= ST_DONE;
            cs_reg    <= 1'b0;
            rd_wr_reg <= 1'b1;
            done_reg  <= 1'b1;
          end else if (op_reg == OP_MOV) begin
            state_reg   <= ST_WR_A;
            rd_wr_reg   <= 1'b0;
            address_reg <= dst_reg;
            wdata_reg   <= data;
            data_oe_reg <= 1'b1;
          end else begin
            // SWAP: read the destination next.
            state_reg   <= ST_RD_B;
            address_reg <= dst_reg;
          end
        end
        ST_RD_B: begin
          temp_b_reg  <= data;
          state_reg   <= ST_WR_A;
          rd_wr_reg   <= 1'b0;
          address_reg <= dst_reg;
          wdata_reg   <= temp_reg;
          data_oe_reg <= 1'b1;
        end
        ST_WR_A: begin
          if (op_reg == OP_SWAP) begin
            state_reg   <= ST_WR_B;
            address_reg <= src_reg;
            wdata_reg   <= temp_b_reg;
          end else begin
            state_reg   <= ST_DONE;
            cs_reg      <= 1'b0;
            rd_wr_reg   <= 1'b1;
            data_oe_reg <= 1'b0;
            done_reg    <= 1'b1;
          end
        end
        ST_WR_B: begin
          state_reg   <= ST_DONE;
          cs_reg      <= 1'b0;
          rd_wr_reg   <= 1'b1;
          data_oe_reg <= 1'b0;
          done_reg    <= 1'b1;
        end
        ST_DONE: begin
          // Single completion cycle; any req seen here is dropped.
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg   <= ST_IDLE;
          busy_reg    <= 1'b0;
          cs_reg      <= 1'b0;
          rd_wr_reg   <= 1'b1;
          data_oe_reg <= 1'b0;
        end
      endcase
    end
  end

  assign xif.busy    = busy_reg;
  assign xif.done    = done_reg;
  assign xif.err     = err_reg;
  assign xif.rdata   = rdata_reg;
  assign xif.address = address_reg;
  assign xif.CS      = cs_reg;
  assign xif.RD_WR   = rd_wr_reg;

  bus_driver #(
    .WIDTH (DWIDTH)
  ) u_bus_driver (
    .en  (data_oe_reg),
    .din (wdata_reg),
    .bus (data)
  );

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// tb_reg_transfer_ctrl -- directed and random transfers against a register
// bank model on the tristate bus; expected register contents, rdata, latency
// and bus-cycle counts come from an array-level model of each op.
module tb_reg_transfer_ctrl;
  import reg_transfer_ctrl_pkg::*;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  wire  [DW-1:0] data;
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] bank [8];
  logic [DW-1:0] mem  [8];
  logic [DW-1:0] model_rdata = '0;

  reg_transfer_ctrl_if #(.ADDR_WIDTH(AW), .DWIDTH(DW)) xif ();

  reg_transfer_ctrl #(
    .ADDR_WIDTH (AW),
    .DWIDTH     (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .xif   (xif.slave),
    .data  (data)
  );

  always #5 clk = ~clk;

  // Register bank: drives the bus on reads, captures it at the end of writes.
  assign data = (xif.CS && xif.RD_WR) ? bank[xif.address] : {DW{1'bz}};
  always @(posedge clk) if (xif.CS && !xif.RD_WR) bank[xif.address] <= data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: never drive while reading, never select in IDLE or DONE.
  always @(negedge clk) begin
    check("mon_drive_on_read", {31'b0, dut.data_oe_reg & xif.RD_WR}, 32'd0);
    check("mon_cs_idle_done", {31'b0, xif.CS & (~xif.busy | xif.done)}, 32'd0);
  end

  task automatic do_op(input logic [1:0] o, input logic [2:0] s, input logic [2:0] d,
                       input logic [7:0] im, input bit hold);
    int lat, ncs, nwr, obs_cs, obs_wr, ndone, done_at, stray_err;
    logic exp_err, err_at_done, busy_ok;
    logic [7:0] t;
    string pfx;
    pfx = $sformatf("op%0d_s%0d_d%0d", o, s, d);
    exp_err = 1'b0;
    case (o)
      2'b00: begin lat = 3; ncs = 2; nwr = 1; mem[d] = mem[s]; end
      2'b01: begin lat = 2; ncs = 1; nwr = 1; mem[d] = im; end
      2'b10: begin lat = 2; ncs = 1; nwr = 0; model_rdata = mem[s]; end
      default: begin
`ifdef XFER_SWAP_EN
        lat = 5; ncs = 4; nwr = 2;
        t = mem[s]; mem[s] = mem[d]; mem[d] = t;
`else
        lat = 1; ncs = 0; nwr = 0; exp_err = 1'b1;
`endif
      end
    endcase
    @(negedge clk);
    xif.req = 1'b1; xif.op = o; xif.src = s; xif.dst = d; xif.imm = im;
    @(posedge clk);
    obs_cs = 0; obs_wr = 0; ndone = 0; done_at = 0; stray_err = 0;
    err_at_done = 1'b0; busy_ok = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (xif.done) begin
        ndone++;
        if (done_at == 0) begin done_at = k; err_at_done = xif.err; end
      end else if (xif.err) stray_err++;
      if (xif.busy !== (k <= lat)) busy_ok = 1'b0;
      if (xif.CS) begin
        obs_cs++;
        if (!xif.RD_WR) obs_wr++;
      end
      if (hold && k <= lat) begin
        xif.req = 1'b1; xif.op = 2'($urandom); xif.src = 3'($urandom);
        xif.dst = 3'($urandom); xif.imm = 8'($urandom);
      end else xif.req = 1'b0;
    end
    xif.req = 1'b0;
    check({pfx, "_done_latency"}, done_at, lat);
    check({pfx, "_done_pulses"}, ndone, 1);
    check({pfx, "_err"}, {31'b0, err_at_done}, {31'b0, exp_err});
    check({pfx, "_stray_err"}, stray_err, 0);
    check({pfx, "_busy_window"}, {31'b0, busy_ok}, 32'd1);
    check({pfx, "_cs_cycles"}, obs_cs, ncs);
    check({pfx, "_write_cycles"}, obs_wr, nwr);
    check({pfx, "_rdata"}, xif.rdata, model_rdata);
    for (int r = 0; r < 8; r++) check($sformatf("%s_reg%0d", pfx, r), bank[r], mem[r]);
  endtask

  initial begin
    int ndone;
    logic [7:0] prior;
    xif.req = 1'b0; xif.op = '0; xif.src = '0; xif.dst = '0; xif.imm = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", xif.busy, 0);
    check("rst_done", xif.done, 0);
    check("rst_err", xif.err, 0);
    check("rst_cs", xif.CS, 0);
    check("rst_rd_wr", xif.RD_WR, 1);
    check("rst_address", xif.address, 0);
    check("rst_rdata", xif.rdata, 0);
    check("rst_temp", dut.temp_reg, 0);
    check("rst_data_oe", dut.data_oe_reg, 0);
    reset = 1'b1;

    // Load every register with a known random value.
    for (int r = 0; r < 8; r++) do_op(OP_LDI, 3'd0, 3'(r), 8'($urandom), 1'b0);

    // LDI then RD back.
    do_op(OP_LDI, 3'd0, 3'd3, 8'hA5, 1'b0);
    do_op(OP_RD, 3'd3, 3'd0, 8'h00, 1'b0);
    check("ldi_rd_a5", xif.rdata, 8'hA5);

    // MOV chain.
    do_op(OP_LDI, 3'd0, 3'd1, 8'h3C, 1'b0);
    do_op(OP_MOV, 3'd1, 3'd6, 8'h00, 1'b0);
    do_op(OP_RD, 3'd6, 3'd0, 8'h00, 1'b0);
    check("mov_rd_3c", xif.rdata, 8'h3C);
    do_op(OP_RD, 3'd1, 3'd0, 8'h00, 1'b0);
    check("mov_src_kept", xif.rdata, 8'h3C);

    // Op 11: SWAP when enabled, otherwise immediate error.
    do_op(OP_LDI, 3'd0, 3'd2, 8'h11, 1'b0);
    do_op(OP_LDI, 3'd0, 3'd5, 8'hEE, 1'b0);
    do_op(OP_SWAP, 3'd2, 3'd5, 8'h00, 1'b0);
    do_op(OP_RD, 3'd2, 3'd0, 8'h00, 1'b0);
    check("swap_rd2", xif.rdata, SWAP_EN ? 8'hEE : 8'h11);
    do_op(OP_RD, 3'd5, 3'd0, 8'h00, 1'b0);
    check("swap_rd5", xif.rdata, SWAP_EN ? 8'h11 : 8'hEE);

    // src == dst, and requests held high while busy and through DONE.
    do_op(OP_MOV, 3'd4, 3'd4, 8'h00, 1'b0);
    do_op(OP_MOV, 3'd0, 3'd7, 8'h00, 1'b1);
    do_op(OP_LDI, 3'd0, 3'd2, 8'h5A, 1'b1);
    do_op(OP_RD, 3'd2, 3'd0, 8'h00, 1'b1);
    do_op(OP_SWAP, 3'd1, 3'd2, 8'h00, 1'b1);

    // Reset during the write cycle of a MOV aborts it.
    prior = mem[6];
    @(negedge clk);
    xif.req = 1'b1; xif.op = OP_MOV; xif.src = 3'd0; xif.dst = 3'd6;
    @(posedge clk);
    @(negedge clk);
    xif.req = 1'b0;
    @(negedge clk);
    check("abort_in_write", {30'b0, xif.CS, xif.RD_WR}, 32'd2);
    reset = 1'b0;
    #1;
    check("abort_cs", xif.CS, 0);
    check("abort_data_oe", dut.data_oe_reg, 0);
    check("abort_busy", xif.busy, 0);
    check("abort_rd_wr", xif.RD_WR, 1);
    check("abort_rdata", xif.rdata, 0);
    model_rdata = '0;
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (xif.done || xif.busy) ndone++;
    end
    check("abort_no_resume", ndone, 0);
    do_op(OP_RD, 3'd6, 3'd0, 8'h00, 1'b0);
    check("abort_prior_value", xif.rdata, prior);

    // Random traffic.
    for (int n = 0; n < 40; n++)
      do_op(2'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
